axi_rd_arbiter_n: RTL

// N-master AXI4 read-channel arbiter with burst support. Successor to the fixed 2-master IF/MEM read arbiter.

---
 rtl/axi_rd_arbiter_n.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/axi_rd_arbiter_n.sv
// N-master AXI4 read-channel arbiter: one burst outstanding, round-robin or fixed priority,
// AR forwarded from the granted master and the full R burst routed back to it.
module axi_rd_arbiter_n #(
    parameter  int NM = 2,
    parameter  int AW = 32,
    parameter  int DW = 64,
    parameter  int RR = 1,
    localparam int GW = (NM > 1) ? $clog2(NM) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NM*AW-1:0]    m_araddr,
    input  logic [NM-1:0]       m_arvalid,
    input  logic [NM*2-1:0]     m_arburst,
    input  logic [NM*8-1:0]     m_arlen,
    input  logic [NM*3-1:0]     m_arsize,
    output logic [NM-1:0]       m_arready,
    output logic [NM*DW-1:0]    m_rdata,
    output logic [NM*2-1:0]     m_rresp,
    output logic [NM-1:0]       m_rvalid,
    output logic [NM-1:0]       m_rlast,
    input  logic [NM-1:0]       m_rready,
    output logic [AW-1:0]       s_araddr,
    output logic                s_arvalid,
    output logic [1:0]          s_arburst,
    output logic [7:0]          s_arlen,
    output logic [2:0]          s_arsize,
    input  logic                s_arready,
    input  logic [DW-1:0]       s_rdata,
    input  logic [1:0]          s_rresp,
    input  logic                s_rvalid,
    input  logic                s_rlast,
    output logic                s_rready,
    output logic [GW-1:0]       grant_id,
    output logic                err_len
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t        state;
    logic [GW-1:0] last;
    logic [7:0]    beat_cnt;
    logic [GW-1:0] winner;

    logic [AW-1:0] araddr_a [NM];
    logic [1:0]    arburst_a [NM];
    logic [7:0]    arlen_a [NM];
    logic [2:0]    arsize_a [NM];

    for (genvar i = 0; i < NM; i++) begin : g_unpack
        assign araddr_a[i]  = m_araddr[i*AW +: AW];
        assign arburst_a[i] = m_arburst[i*2 +: 2];
        assign arlen_a[i]   = m_arlen[i*8 +: 8];
        assign arsize_a[i]  = m_arsize[i*3 +: 3];
    end

    // Round-robin scans from the master after the last one served; fixed priority favours index 0.
    function automatic logic [GW-1:0] pick(input logic [NM-1:0] req, input logic [GW-1:0] ptr);
        logic [GW-1:0] w;
        logic [GW-1:0] gi;
        logic          found;
        int            idx;
        w     = '0;
        found = 1'b0;
        if (RR != 0) begin
            for (int i = 1; i <= NM; i++) begin
                idx = (int'(ptr) + i) % NM;
                gi  = GW'(idx);
                if (!found && req[gi]) begin
                    w     = gi;
                    found = 1'b1;
                end
            end
        end else begin
            for (int i = NM - 1; i >= 0; i--) begin
                if (req[GW'(i)]) w = GW'(i);
            end
        end
        return w;
    endfunction

    assign winner  = pick(m_arvalid, last);
    assign m_rdata = {NM{s_rdata}};
    assign m_rresp = {NM{s_rresp}};

    always_comb begin
        s_araddr  = araddr_a[grant_id];
        s_arburst = arburst_a[grant_id];
        s_arlen   = arlen_a[grant_id];
        s_arsize  = arsize_a[grant_id];
        s_arvalid = 1'b0;
        s_rready  = 1'b0;
        m_arready = '0;
        m_rvalid  = '0;
        m_rlast   = '0;
        case (state)
            ADDR: begin
                s_arvalid           = m_arvalid[grant_id];
                m_arready[grant_id] = s_arready;
            end
            DATA: begin
                m_rvalid[grant_id] = s_rvalid;
                m_rlast[grant_id]  = s_rlast;
                s_rready           = m_rready[grant_id];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            grant_id <= '0;
            last     <= GW'(NM - 1);
            beat_cnt <= '0;
            err_len  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|m_arvalid) begin
                        grant_id <= winner;
                        state    <= ADDR;
                    end
                end
                ADDR: begin
                    if (s_arvalid && s_arready) begin
                        beat_cnt <= s_arlen;
                        state    <= DATA;
                    end
                end
                DATA: begin
                    if (s_rvalid && s_rready) begin
                        // Length mismatches are flagged, but only rlast ever closes the burst.
                        if (s_rlast) begin
                            if (beat_cnt != 8'd0) err_len <= 1'b1;
                            last  <= grant_id;
                            state <= IDLE;
                        end else if (beat_cnt == 8'd0) begin
                            err_len <= 1'b1;
                        end else begin
                            beat_cnt <= beat_cnt - 8'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
